// File: rtl/udp_frame_sched_if.sv
// Scheduler <-> requester/checker signal bundle for udp_frame_sched.
// master is the scheduler side; slave is the requester/checker side.
interface udp_frame_sched_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       req;
    logic             valid_ip;
    logic             sel;
    logic             frame_start;
    logic [1:0]       done;
    logic             verdict;
    logic             busy;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        input  req, valid_ip,
        output sel, frame_start, done, verdict, busy, pass_cnt, drop_cnt
    );

    modport slave (
        output req, valid_ip,
        input  sel, frame_start, done, verdict, busy, pass_cnt, drop_cnt
    );
endinterface

// File: rtl/udp_frame_sched.sv
// Two-requester round-robin scheduler for a shared IPv4 frame checker.
// It issues a start pulse, samples the verdict CHECK_LAT cycles later, reports to the granted requester and counts the outcome.
module udp_frame_sched #(
    parameter int CHECK_LAT = 2,
    parameter int CNT_W     = 16
) (
    input  logic               main_clk,
    input  logic               main_rst,
    udp_frame_sched_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic [3:0]       LAT     = CHECK_LAT[3:0];
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic             verdict_q, verdict_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            verdict_q <= 1'b0;
            cnt_q     <= 4'd0;
            pass_q    <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            verdict_q <= verdict_d;
            cnt_q     <= cnt_d;
            pass_q    <= pass_d;
            drop_q    <= drop_d;
        end
    end

    // Next-state, arbitration, latency countdown and saturating counters.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        verdict_d = verdict_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        drop_d    = drop_q;
        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    state_d = START;
                    case (bus.req)
                        2'b01:   sel_d = 1'b0;
                        2'b10:   sel_d = 1'b1;
                        default: sel_d = ~last_q;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                cnt_d   = LAT;
                state_d = WAIT;
            end
            WAIT: begin
                // A zero count can only come from a corrupted register; sample rather than stall.
                if (cnt_q <= 4'd1) begin
                    verdict_d = bus.valid_ip;
                    cnt_d     = 4'd0;
                    state_d   = REPORT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            REPORT: begin
                last_d  = sel_q;
                state_d = IDLE;
                if (verdict_q) begin
                    if (pass_q != CNT_MAX) begin
                        pass_d = pass_q + CNT_ONE;
                    end else begin
                        pass_d = pass_q;
                    end
                end else begin
                    if (drop_q != CNT_MAX) begin
                        drop_d = drop_q + CNT_ONE;
                    end else begin
                        drop_d = drop_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.sel         = sel_q;
    assign bus.frame_start = (state_q == START);
    assign bus.done        = (state_q == REPORT) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.verdict     = verdict_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.pass_cnt    = pass_q;
    assign bus.drop_cnt    = drop_q;
endmodule
